// File: rtl/regfile_wb_scheduler_pkg.sv
// Purpose : shared constants and types for the register-file writeback scheduler.
// Contents: register address width, well-known register numbers and the
//           write-port grant encoding used between the arbiter and the top.
// Config  : none (the RFWB_EARLY_RELEASE_EN option lives in regfile_wb_scheduler.sv).
package rfwb_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // Owner of the register-file write port for the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LONG = 2'd2
    } rfwb_gnt_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Purpose : bundle of the decode-issue, writeback-request and register-file
//           write signals around regfile_wb_scheduler.
// Modports:
//   slave  - the scheduler: samples issue/writeback requests, drives stall,
//            the two writeback readies, rf_we/rf_waddr/rf_wdata, pending_mask.
//   master - the surrounding pipeline: the mirror image of slave.
// Signals :
//   issue_valid/rs/rt/use_rs/use_rt/dest/wr/long : instruction from decode
//   stall                                        : hold decode this cycle
//   pipe_wb_valid/addr/data, pipe_wb_ready       : in-order pipe writeback
//   long_wb_valid/addr/data, long_wb_ready       : mul/div writeback
//   rf_we/rf_waddr/rf_wdata                      : registered write port
//   pending_mask                                 : registered scoreboard bits
interface regfile_wb_scheduler_if
    import rfwb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
);

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rs;
    logic [REG_ADDR_W-1:0] issue_rt;
    logic                  use_rs;
    logic                  use_rt;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic                  issue_wr;
    logic                  issue_long;
    logic                  stall;

    logic                  pipe_wb_valid;
    logic [REG_ADDR_W-1:0] pipe_wb_addr;
    logic [DATA_W-1:0]     pipe_wb_data;
    logic                  pipe_wb_ready;

    logic                  long_wb_valid;
    logic [REG_ADDR_W-1:0] long_wb_addr;
    logic [DATA_W-1:0]     long_wb_data;
    logic                  long_wb_ready;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [NREG-1:0]       pending_mask;

    modport slave (
        input  issue_valid, issue_rs, issue_rt, use_rs, use_rt,
        input  issue_dest, issue_wr, issue_long,
        output stall,
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output pipe_wb_ready,
        input  long_wb_valid, long_wb_addr, long_wb_data,
        output long_wb_ready,
        output rf_we, rf_waddr, rf_wdata, pending_mask
    );

    modport master (
        output issue_valid, issue_rs, issue_rt, use_rs, use_rt,
        output issue_dest, issue_wr, issue_long,
        input  stall,
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  pipe_wb_ready,
        output long_wb_valid, long_wb_addr, long_wb_data,
        input  long_wb_ready,
        input  rf_we, rf_waddr, rf_wdata, pending_mask
    );

endinterface

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Purpose : single-port write arbiter between the in-order pipe writeback and
//           the long-latency mul/div writeback. The pipe normally wins; after
//           STARVE_LIMIT consecutive lost cycles the long unit is forced a grant.
// Ports   :
//   i_clock, i_reset : clock (rising edge) and async active-high reset
//   i_pipe_valid     : pipe writeback request
//   i_long_valid     : mul/div writeback request
//   o_grant          : combinational grant for this cycle
module rfwb_arbiter
    import rfwb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic      i_clock,
    input  logic      i_reset,
    input  logic      i_pipe_valid,
    input  logic      i_long_valid,
    output rfwb_gnt_e o_grant
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_d;
    logic             w_limit_hit;

    assign w_limit_hit = (r_starve_cnt == LIMIT);

    always_comb begin
        o_grant = GNT_NONE;
        if (i_long_valid && (!i_pipe_valid || w_limit_hit)) begin
            o_grant = GNT_LONG;
        end else if (i_pipe_valid) begin
            o_grant = GNT_PIPE;
        end
    end

    // Counts cycles the long unit has waited behind the pipe; saturates at the limit.
    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        if (!i_long_valid || (o_grant == GNT_LONG)) begin
            w_starve_cnt_d = '0;
        end else if ((o_grant == GNT_PIPE) && !w_limit_hit) begin
            w_starve_cnt_d = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Purpose : register scoreboard and write-port scheduler for the 32x32 register
//           file. Tracks destinations with writes in flight, stalls decode on
//           RAW/WAW hazards or a busy mul/div unit, and shares the single write
//           port between pipe writeback and mul/div writeback (rfwb_arbiter).
// Ports   :
//   i_clock, i_reset : clock (rising edge) and async active-high reset
//   io_bus           : regfile_wb_scheduler_if.slave (issue, writeback requests,
//                      stall, readies, registered rf write port, pending_mask)
// Config  : `define RFWB_EARLY_RELEASE_EN lets a register (and the mul/div busy
//           flag) released by this cycle's grant be treated as free by the stall
//           logic in the same cycle. Default build: stall uses registered state.
module regfile_wb_scheduler
    import rfwb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NREG         = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    regfile_wb_scheduler_if.slave  io_bus
);

    logic [NREG-1:0]       r_pending;
    logic                  r_long_busy;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;

    rfwb_gnt_e             w_gnt;
    logic                  w_pipe_gnt;
    logic                  w_long_gnt;
    logic                  w_gnt_any;
    logic [REG_ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0]     w_gnt_data;

    logic [NREG-1:0]       w_clr_mask;
    logic [NREG-1:0]       w_set_mask;
    logic [NREG-1:0]       w_pending_d;
    logic [NREG-1:0]       w_pend_eff;
    logic                  w_long_busy_eff;

    logic                  w_hazard_rs;
    logic                  w_hazard_rt;
    logic                  w_hazard_dest;
    logic                  w_long_conflict;
    logic                  w_stall;
    logic                  w_issue_fire;

    // ---------------------------------------------------------------- arbitration
    rfwb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_pipe_valid (io_bus.pipe_wb_valid),
        .i_long_valid (io_bus.long_wb_valid),
        .o_grant      (w_gnt)
    );

    assign w_pipe_gnt = (w_gnt == GNT_PIPE);
    assign w_long_gnt = (w_gnt == GNT_LONG);
    assign w_gnt_any  = w_pipe_gnt | w_long_gnt;
    assign w_gnt_addr = w_long_gnt ? io_bus.long_wb_addr : io_bus.pipe_wb_addr;
    assign w_gnt_data = w_long_gnt ? io_bus.long_wb_data : io_bus.pipe_wb_data;

    assign io_bus.pipe_wb_ready = w_pipe_gnt;
    assign io_bus.long_wb_ready = w_long_gnt;

    always_comb begin
        w_clr_mask = '0;
        if (w_gnt_any) begin
            w_clr_mask[w_gnt_addr] = 1'b1;
        end
    end

    // ---------------------------------------------------------------- hazard check
`ifdef RFWB_EARLY_RELEASE_EN
    assign w_pend_eff      = r_pending & ~w_clr_mask;
    assign w_long_busy_eff = r_long_busy & ~w_long_gnt;
`else
    assign w_pend_eff      = r_pending;
    assign w_long_busy_eff = r_long_busy;
`endif

    assign w_hazard_rs     = io_bus.use_rs   & w_pend_eff[io_bus.issue_rs];
    assign w_hazard_rt     = io_bus.use_rt   & w_pend_eff[io_bus.issue_rt];
    assign w_hazard_dest   = io_bus.issue_wr & w_pend_eff[io_bus.issue_dest];
    assign w_long_conflict = io_bus.issue_long & w_long_busy_eff;

    assign w_stall      = io_bus.issue_valid &
                          (w_hazard_rs | w_hazard_rt | w_hazard_dest | w_long_conflict);
    assign w_issue_fire = io_bus.issue_valid & ~w_stall;
    assign io_bus.stall = w_stall;

    // ---------------------------------------------------------------- scoreboard
    always_comb begin
        w_set_mask = '0;
        if (w_issue_fire && io_bus.issue_wr && (io_bus.issue_dest != REG_ZERO)) begin
            w_set_mask[io_bus.issue_dest] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit pending.
    always_comb begin
        w_pending_d    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending   <= '0;
            r_long_busy <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
            if (w_issue_fire && io_bus.issue_long) begin
                r_long_busy <= 1'b1;
            end else if (w_long_gnt) begin
                r_long_busy <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- write port
    // Writes to register 0 are granted (the requester retires) but never reach the file.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_gnt_any && (w_gnt_addr != REG_ZERO);
            if (w_gnt_any) begin
                r_rf_waddr <= w_gnt_addr;
                r_rf_wdata <= w_gnt_data;
            end
        end
    end

    assign io_bus.rf_we        = r_rf_we;
    assign io_bus.rf_waddr     = r_rf_waddr;
    assign io_bus.rf_wdata     = r_rf_wdata;
    assign io_bus.pending_mask = r_pending;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler. Expected register-file writes go into
// a queue when a grant is expected; a monitor pops one per observed rf_we.
module tb_regfile_wb_scheduler;
    import rfwb_pkg::*;

`ifdef RFWB_EARLY_RELEASE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    wr_t  exp_q[$];

    regfile_wb_scheduler_if #(.DATA_W(32), .NREG(32)) bus ();

    regfile_wb_scheduler #(
        .DATA_W       (32),
        .NREG         (32),
        .STARVE_LIMIT (3)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_rs      = 5'd0;
        bus.issue_rt      = 5'd0;
        bus.use_rs        = 1'b0;
        bus.use_rt        = 1'b0;
        bus.issue_dest    = 5'd0;
        bus.issue_wr      = 1'b0;
        bus.issue_long    = 1'b0;
        bus.pipe_wb_valid = 1'b0;
        bus.pipe_wb_addr  = 5'd0;
        bus.pipe_wb_data  = 32'h0;
        bus.long_wb_valid = 1'b0;
        bus.long_wb_addr  = 5'd0;
        bus.long_wb_data  = 32'h0;
    endtask

    task automatic issue_wr(input logic [4:0] dest);
        bus.issue_valid = 1'b1;
        bus.issue_wr    = 1'b1;
        bus.issue_dest  = dest;
    endtask

    // Monitor: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.rf_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h, expected none",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                             bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int m;
        bit exp_long;
        n_tests = 0;
        n_fail  = 0;

        // ---- reset state (a reader of $5 is presented; nothing is pending)
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.issue_valid = 1'b1;
        bus.use_rs      = 1'b1;
        bus.issue_rs    = 5'd5;
        @(negedge clk);
        check("reset_pending", bus.pending_mask, 32'h0);
        check("reset_rf_we", bus.rf_we, 1'b0);
        check("reset_stall", bus.stall, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        // ---- RAW hazard on $5 cleared by a pipe writeback
        issue_wr(5'd5);
        @(negedge clk);
        check("raw_first_issue_stall", bus.stall, 1'b0);
        tick();
        check("raw_pending5", bus.pending_mask, 32'h20);
        issue_wr(5'd6);
        bus.use_rs   = 1'b1;
        bus.issue_rs = 5'd5;
        @(negedge clk);
        check("raw_stall", bus.stall, 1'b1);
        tick();
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd5;
        bus.pipe_wb_data  = 32'h1234;
        @(negedge clk);
        check("raw_pipe_ready", bus.pipe_wb_ready, 1'b1);
        check("raw_grant_cycle_stall", bus.stall, EARLY ? 1'b0 : 1'b1);
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        tick();
        bus.pipe_wb_valid = 1'b0;
        bus.issue_valid   = !EARLY;
        @(negedge clk);
        check("raw_pending_after_wb", bus.pending_mask, EARLY ? 32'h40 : 32'h0);
        check("raw_stall_after_wb", bus.stall, 1'b0);
        tick();
        idle();
        check("raw_pending6", bus.pending_mask, 32'h40);

        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd6;
        bus.pipe_wb_data  = 32'hCAFE;
        @(negedge clk);
        check("wb6_ready", bus.pipe_wb_ready, 1'b1);
        exp_q.push_back('{addr: 5'd6, data: 32'hCAFE});
        tick();
        idle();
        check("wb6_pending", bus.pending_mask, 32'h0);

        // ---- writeback to $0: granted, no write
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd0;
        bus.pipe_wb_data  = 32'hDEAD;
        @(negedge clk);
        check("r0_ready", bus.pipe_wb_ready, 1'b1);
        tick();
        idle();
        check("r0_rf_we", bus.rf_we, 1'b0);
        check("r0_pending", bus.pending_mask, 32'h0);

        // ---- both requesters held: pipe,pipe,pipe,long repeating
        k = 1;
        m = 0;
        bus.pipe_wb_valid = 1'b1;
        bus.long_wb_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.pipe_wb_addr = 5'(k);
            bus.pipe_wb_data = 32'h100 + 32'(k);
            bus.long_wb_addr = 5'(20 + m);
            bus.long_wb_data = 32'h200 + 32'(m);
            exp_long = ((i % 4) == 3);
            @(negedge clk);
            check("arb_pipe_ready", bus.pipe_wb_ready, !exp_long);
            check("arb_long_ready", bus.long_wb_ready, exp_long);
            if (exp_long) begin
                exp_q.push_back('{addr: 5'(20 + m), data: 32'h200 + 32'(m)});
                m++;
            end else begin
                exp_q.push_back('{addr: 5'(k), data: 32'h100 + 32'(k)});
                k++;
            end
            tick();
        end
        idle();

        // ---- mul/div busy blocks a second long issue
        issue_wr(5'd12);
        bus.issue_long = 1'b1;
        @(negedge clk);
        check("long_first_stall", bus.stall, 1'b0);
        tick();
        check("long_pending12", bus.pending_mask, 32'h1000);
        bus.issue_dest = 5'd13;
        @(negedge clk);
        check("long_conflict_stall", bus.stall, 1'b1);
        tick();
        bus.long_wb_valid = 1'b1;
        bus.long_wb_addr  = 5'd12;
        bus.long_wb_data  = 32'h600D;
        @(negedge clk);
        check("long_ready", bus.long_wb_ready, 1'b1);
        check("long_grant_cycle_stall", bus.stall, EARLY ? 1'b0 : 1'b1);
        exp_q.push_back('{addr: 5'd12, data: 32'h600D});
        tick();
        bus.long_wb_valid = 1'b0;
        bus.issue_valid   = !EARLY;
        @(negedge clk);
        check("long_stall_after_grant", bus.stall, 1'b0);
        tick();
        idle();
        check("long_pending13", bus.pending_mask, 32'h2000);
        bus.issue_valid = 1'b1;
        bus.issue_long  = 1'b1;
        @(negedge clk);
        check("long_still_busy", bus.stall, 1'b1);
        tick();
        idle();
        bus.long_wb_valid = 1'b1;
        bus.long_wb_addr  = 5'd13;
        bus.long_wb_data  = 32'h1313;
        exp_q.push_back('{addr: 5'd13, data: 32'h1313});
        tick();
        idle();
        check("long_pending_clear", bus.pending_mask, 32'h0);

        // ---- same-cycle release and re-issue of $7
        issue_wr(5'd7);
        tick();
        check("rel_pending7", bus.pending_mask, 32'h80);
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd7;
        bus.pipe_wb_data  = 32'h77;
        @(negedge clk);
        check("rel_stall", bus.stall, EARLY ? 1'b0 : 1'b1);
        exp_q.push_back('{addr: 5'd7, data: 32'h77});
        tick();
        idle();
        check("rel_pending_after", bus.pending_mask, EARLY ? 32'h80 : 32'h0);
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd7;
        bus.pipe_wb_data  = 32'h78;
        exp_q.push_back('{addr: 5'd7, data: 32'h78});
        tick();
        idle();
        check("rel_pending_clear", bus.pending_mask, 32'h0);

        // ---- async reset with $5,$7 pending and a waiting long request
        issue_wr(5'd5);
        tick();
        issue_wr(5'd7);
        tick();
        idle();
        check("rst_pending_a0", bus.pending_mask, 32'hA0);
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd1;
        bus.pipe_wb_data  = 32'h11;
        bus.long_wb_valid = 1'b1;
        bus.long_wb_addr  = 5'd3;
        bus.long_wb_data  = 32'h33;
        bus.issue_valid   = 1'b1;
        bus.use_rs        = 1'b1;
        bus.issue_rs      = 5'd5;
        @(negedge clk);
        check("rst_pre_stall", bus.stall, 1'b1);
        check("rst_long_waiting", bus.long_wb_ready, 1'b0);
        tick();
        check("rst_pre_rf_we", bus.rf_we, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_pending", bus.pending_mask, 32'h0);
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Scoreboard and write-port arbiter for the 32x32 general register file.
- Tracks destination registers with writes in flight and stalls decode on RAW/WAW hazards.
- Shares the single register-file write port between the in-order pipe writeback (ALU/load/link) and the long-latency multiply/divide unit.
- Sits between decode and the register file write port.

Parameters:
- DATA_W, 32, register data width
- NREG, 32, number of registers (address width 5)
- STARVE_LIMIT, 3, consecutive lost-arbitration cycles before the long unit is forced a grant

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs  in  5  source register 1
- issue_rt  in  5  source register 2
- use_rs  in  1  instruction reads rs
- use_rt  in  1  instruction reads rt
- issue_dest  in  5  destination register (rd, rt or 31)
- issue_wr  in  1  instruction writes issue_dest
- issue_long  in  1  instruction goes to the mul/div unit
- stall  out  1  hold decode; the instruction is not issued this cycle
- pipe_wb_valid  in  1  pipe writeback request
- pipe_wb_addr  in  5  pipe writeback register
- pipe_wb_data  in  DATA_W  pipe writeback data
- pipe_wb_ready  out  1  pipe writeback granted this cycle
- long_wb_valid  in  1  mul/div writeback request
- long_wb_addr  in  5  mul/div writeback register
- long_wb_data  in  DATA_W  mul/div writeback data
- long_wb_ready  out  1  mul/div writeback granted this cycle
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  5  registered write address
- rf_wdata  out  DATA_W  registered write data
- pending_mask  out  NREG  registered pending bits (bit 0 always 0)

Behaviour:
- Reset (async) clears:
  - pending_mask = 0, long_busy = 0, starve_cnt = 0
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - Combinational outputs follow their equations from the cleared state.
- Reset mid-operation discards all in-flight state; requesters must also be reset.
- Stall (combinational, from registered state only):
  - stall = issue_valid & (hazard_rs | hazard_rt | hazard_dest | long_conflict)
  - hazard_rs = use_rs & pending[issue_rs]
  - hazard_rt = use_rt & pending[issue_rt]
  - hazard_dest = issue_wr & pending[issue_dest]
  - long_conflict = issue_long & long_busy
- Issue: when issue_valid & !stall:
  - set pending[issue_dest] if issue_wr and issue_dest != 0.
  - set long_busy if issue_long.
- Arbitration (combinational grant, one per cycle):
  - long granted if long_wb_valid & (!pipe_wb_valid | starve_cnt == STARVE_LIMIT).
  - otherwise pipe granted if pipe_wb_valid.
  - pipe_wb_ready / long_wb_ready reflect the grant.
  - A requester not granted holds valid, addr and data stable.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) when long_wb_valid and the pipe wins.
  - clears on a long grant or when long_wb_valid = 0.
- Grant effects:
  - clear pending[addr] and register the write.
  - rf_we = 1 next cycle with the granted addr/data (latency 1), except addr = 0: grant is still given but rf_we = 0.
  - long grant also clears long_busy.
- No grant: rf_we = 0 next cycle; rf_waddr/rf_wdata hold.
- Set/clear of the same register in one cycle cannot occur without the feature (the dest hazard stalls the issue).
- Writeback to a non-pending register: write performed, pending unchanged.

Optional Feature:
- Macro: RFWB_EARLY_RELEASE_EN.
- Defined: a register being cleared by this cycle's grant is treated as not pending for the stall equations, and long_busy is likewise treated as released on a long grant.
  - Same-cycle set and clear of one register: set wins (pending stays 1).
  - Same-cycle long_busy set and clear: set wins.
- Undefined: stall uses registered state only; one extra stall cycle per dependent issue.

Decomposition:
- Package rfwb_pkg: REG_ADDR_W = 5, REG_ZERO = 5'd0, REG_RA = 5'd31, grant encoding enum {GNT_NONE, GNT_PIPE, GNT_LONG}.
- One sub-module, rfwb_arbiter: the grant and starve counter logic.
- Scoreboard bits and output registers stay in the top.

Test Plan:
- Issue add $5 (issue_wr, dest 5); next cycle issue with use_rs, rs = 5 -> stall = 1; pipe writeback $5 = 0x1234 granted -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234, pending[5] = 0, stall = 0.
- pipe_wb_valid and long_wb_valid both held continuously -> pipe granted 3 cycles, long granted on the 4th, starve_cnt returns to 0.
- Issue mult while long_busy = 1 -> stall until the long grant; with RFWB_EARLY_RELEASE_EN, stall drops in the grant cycle itself.
- Writeback to register 0 -> pipe_wb_ready = 1, rf_we = 0, pending_mask unchanged.
- With RFWB_EARLY_RELEASE_EN: pending[7] = 1, grant to $7 and issue with dest 7 in the same cycle -> no stall, pending[7] = 1 afterwards.
- Assert reset while pending_mask = 0x0000_00A0 and a long request is waiting -> immediately pending_mask = 0, rf_we = 0, stall = 0.
